router_fifo_param: RTL and testbench

Parametrised packet-aware FIFO for the router datapath. It generalises the fixed 16x9 router FIFO to configurable data width, depth and almost-full threshold, and keeps a per-entry header flag (the lfd bit). It also tracks packet boundaries on the read side, reports fill level and stored-packet count, and latches sticky overflow/underflow errors. One instance sits between the router synchroniser/FSM write side and each output channel's read side.

---
 rtl/router_fifo_param.sv | 158 +++++++++++++++
 tb/tb_router_fifo_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_param.sv
// Parametrised packet-aware FIFO: stores {lfd, data} per entry, tracks packet
// boundaries on the read side, reports fill level and packet count, and latches sticky errors.
module router_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               soft_reset,
    input  logic               write_enb,
    input  logic               read_enb,
    input  logic               lfd_state,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid,
    output logic               pkt_end,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic               overflow,
    output logic               underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = WIDTH - 1;

    logic [WIDTH:0]     mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [AW:0]        level_q, level_d;
    logic [AW:0]        pkt_count_q, pkt_count_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               pkt_end_q, pkt_end_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               empty_w;
    logic               full_w;
    logic               push;
    logic               pop;
    logic [WIDTH:0]     rd_entry;
    logic               rd_hdr;
    logic [WIDTH-3:0]   rd_len;

    assign empty_w  = (level_q == '0);
    assign full_w   = (level_q == (AW+1)'(DEPTH));
    assign pop      = read_enb & ~empty_w;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign push     = write_enb & (~full_w | pop);
    assign rd_entry = mem_q[rptr_q];
    assign rd_hdr   = rd_entry[WIDTH];
    assign rd_len   = rd_entry[WIDTH-1:2];

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        level_d      = level_q;
        pkt_count_d  = pkt_count_q;
        rem_d        = rem_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        pkt_end_d    = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (soft_reset) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            pkt_count_d = '0;
            rem_d       = '0;
            data_out_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d       = rptr_q + AW'(1);
                data_out_d   = rd_entry[WIDTH-1:0];
                data_valid_d = 1'b1;
                // Header reload covers payload plus the trailing parity byte.
                if (rd_hdr) begin
                    rem_d = {1'b0, rd_len} + RW'(1);
                end else if (rem_q != '0) begin
                    rem_d     = rem_q - RW'(1);
                    pkt_end_d = (rem_q == RW'(1));
                end
            end

            case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase

            if ((push & lfd_state) & ~(pop & rd_hdr)) begin
                pkt_count_d = pkt_count_q + (AW+1)'(1);
            end else if (~(push & lfd_state) & (pop & rd_hdr)) begin
                pkt_count_d = pkt_count_q - (AW+1)'(1);
            end

            overflow_d  = overflow_q | (write_enb & full_w & ~pop);
            underflow_d = underflow_q | (read_enb & empty_w);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            pkt_count_q  <= '0;
            rem_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            pkt_count_q  <= pkt_count_d;
            rem_q        <= rem_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            pkt_end_q    <= pkt_end_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; only pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push && !soft_reset) begin
            mem_q[wptr_q] <= {lfd_state, data_in};
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign pkt_end     = pkt_end_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign almost_full = (level_q >= (AW+1)'(AF_LEVEL));
    assign level       = level_q;
    assign pkt_count   = pkt_count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_router_fifo_param.sv
// Bench for router_fifo_param: directed packet scenarios plus random traffic,
// checked against a queue-based behavioural model.
module tb_router_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       pkt_end;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic [4:0] pkt_count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // model state
    logic [8:0] mq[$];
    logic [7:0] m_dout;
    logic       m_dv, m_pend, m_ovf, m_unf;
    int         m_rem;

    router_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .pkt_end(pkt_end), .empty(empty), .full(full), .almost_full(almost_full),
        .level(level), .pkt_count(pkt_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    function automatic int m_hdrs();
        int n = 0;
        foreach (mq[i]) if (mq[i][8]) n++;
        return n;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_dout = '0; m_dv = 0; m_pend = 0; m_ovf = 0; m_unf = 0; m_rem = 0;
    endtask

    // Drive one clock of stimulus, advance the model at the edge, settle 1ns.
    task automatic cycle(input logic we, input logic re, input logic lfd,
                         input logic [7:0] din, input logic sr);
        logic [8:0] e;
        bit pop_ok, push_ok;
        write_enb = we; read_enb = re; lfd_state = lfd; data_in = din; soft_reset = sr;
        @(posedge clock);
        if (sr) begin
            model_clear();
        end else begin
            pop_ok  = re && (mq.size() > 0);
            push_ok = we && ((mq.size() < DEPTH) || pop_ok);
            if (we && mq.size() == DEPTH && !pop_ok) m_ovf = 1;
            if (re && mq.size() == 0) m_unf = 1;
            m_dv = 0; m_pend = 0;
            if (pop_ok) begin
                e = mq.pop_front();
                m_dv = 1;
                m_dout = e[7:0];
                if (e[8]) m_rem = int'(e[7:2]) + 1;
                else if (m_rem > 0) begin
                    m_rem--;
                    m_pend = (m_rem == 0);
                end
            end
            if (push_ok) mq.push_back({lfd, din});
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 8'h00, 0);
    endtask

    task automatic flush();
        cycle(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_reset();
        write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 0; soft_reset = 0;
        resetn = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1 resetn = 1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h exp 0", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b exp 0", data_valid); end
        checks++; if (pkt_end !== 1'b0) begin errors++; $display("FAIL reset_pend got %0b exp 0", pkt_end); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_flags got e%0b f%0b af%0b exp e1 f0 af0", empty, full, almost_full); end
        checks++; if (level !== 5'd0 || pkt_count !== 5'd0) begin
            errors++; $display("FAIL reset_level got %0d/%0d exp 0/0", level, pkt_count); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL reset_sticky got o%0b u%0b exp 0 0", overflow, underflow); end
    endtask

    task automatic push_packet16();
        cycle(1, 0, 1, 8'h39, 0);
        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 8'($urandom), 0);
    endtask

    task automatic test_packet();
        int pends;
        flush();
        push_packet16();
        checks++; if (level !== 5'd16 || full !== 1'b1 || almost_full !== 1'b1) begin
            errors++; $display("FAIL pkt_fill got lvl%0d f%0b af%0b exp 16 1 1", level, full, almost_full); end
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL pkt_count got %0d exp 1", pkt_count); end
        pends = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 8'h00, 0);
            checks++; if (data_valid !== 1'b1 || data_out !== m_dout || pkt_end !== m_pend) begin
                errors++; $display("FAIL pkt_pop%0d got v%0b d%0h e%0b exp v1 d%0h e%0b", i, data_valid, data_out, pkt_end, m_dout, m_pend); end
            if (pkt_end === 1'b1) pends++;
            if (i == 0) begin
                checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL pkt_count_hdr got %0d exp 0", pkt_count); end
            end
            if (i == 15) begin
                checks++; if (pkt_end !== 1'b1) begin errors++; $display("FAIL pkt_end_parity got %0b exp 1", pkt_end); end
            end
        end
        checks++; if (pends !== 1) begin errors++; $display("FAIL pkt_end_count got %0d exp 1", pends); end
        idle();
        checks++; if (empty !== 1'b1 || data_valid !== 1'b0 || data_out !== m_dout) begin
            errors++; $display("FAIL pkt_drain got e%0b v%0b d%0h exp e1 v0 d%0h", empty, data_valid, data_out, m_dout); end
    endtask

    task automatic test_overflow();
        logic [7:0] first;
        flush();
        first = 8'($urandom);
        cycle(1, 0, 0, first, 0);
        for (int i = 1; i < 16; i++) cycle(1, 0, 0, 8'($urandom), 0);
        cycle(1, 0, 0, 8'hAA, 0);
        checks++; if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
            errors++; $display("FAIL ovf got o%0b lvl%0d exp o1 16", overflow, level); end
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (data_out !== first || data_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_first got %0h v%0b exp %0h v1", data_out, data_valid, first); end
        idle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    endtask

    task automatic test_back_to_back_full();
        flush();
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'($urandom), 0);
        cycle(1, 1, 0, 8'h55, 0);
        checks++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || data_out !== m_dout) begin
            errors++; $display("FAIL simul got lvl%0d f%0b o%0b d%0h exp 16 1 0 %0h", level, full, overflow, data_out, m_dout); end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 8'h00, 0);
            checks++; if (data_out !== m_dout) begin
                errors++; $display("FAIL simul_pop%0d got %0h exp %0h", i, data_out, m_dout); end
        end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL simul_last got %0h exp 55", data_out); end
    endtask

    task automatic test_underflow();
        flush();
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (underflow !== 1'b1 || data_valid !== 1'b0) begin
            errors++; $display("FAIL unf got u%0b v%0b exp u1 v0", underflow, data_valid); end
        cycle(1, 1, 0, 8'h12, 0);
        checks++; if (level !== 5'd1 || data_valid !== 1'b0 || underflow !== 1'b1) begin
            errors++; $display("FAIL unf_bypass got lvl%0d v%0b u%0b exp 1 0 1", level, data_valid, underflow); end
        cycle(0, 1, 0, 8'h00, 0);
        checks++; if (data_out !== 8'h12 || data_valid !== 1'b1) begin
            errors++; $display("FAIL unf_next got %0h v%0b exp 12 v1", data_out, data_valid); end
    endtask

    task automatic test_soft_reset();
        flush();
        push_packet16();
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00, 0);
        cycle(1, 1, 1, 8'hFF, 1);
        checks++; if (data_out !== 8'h00 || data_valid !== 1'b0 || pkt_end !== 1'b0 || empty !== 1'b1 ||
                      level !== 5'd0 || pkt_count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL soft_rst got d%0h v%0b e%0b em%0b l%0d p%0d", data_out, data_valid, pkt_end, empty, level, pkt_count); end
        cycle(1, 0, 1, 8'h09, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 8'h00, 0);
            checks++; if (pkt_end !== ((i == 3) ? 1'b1 : 1'b0) || data_out !== m_dout) begin
                errors++; $display("FAIL soft_pkt%0d got e%0b d%0h exp e%0b d%0h", i, pkt_end, data_out, (i == 3), m_dout); end
        end
    endtask

    task automatic test_async_reset();
        flush();
        cycle(1, 0, 1, 8'h39, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'($urandom), 0);
        cycle(0, 1, 0, 8'h00, 0);
        write_enb = 0; read_enb = 0;
        #2 resetn = 0;
        #1;
        model_clear();
        checks++; if (level !== 5'd0 || empty !== 1'b1 || pkt_count !== 5'd0 || data_out !== 8'h00 || data_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst got l%0d em%0b p%0d d%0h v%0b", level, empty, pkt_count, data_out, data_valid); end
        @(posedge clock);
        #1 resetn = 1;
    endtask

    task automatic test_wrap();
        flush();
        cycle(1, 0, 0, 8'($urandom), 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 0, 8'($urandom), 0);
            checks++; if (data_out !== m_dout || level !== 5'd1) begin
                errors++; $display("FAIL wrap%0d got d%0h l%0d exp d%0h l1", i, data_out, level, m_dout); end
        end
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 15), 8'($urandom), ($urandom_range(0, 199) == 0));
            checks++;
            if (data_valid !== m_dv || pkt_end !== m_pend || data_out !== m_dout ||
                level !== 5'(mq.size()) || pkt_count !== 5'(m_hdrs()) ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                almost_full !== (mq.size() >= AF) || overflow !== m_ovf || underflow !== m_unf) begin
                errors++;
                $display("FAIL rand%0d got v%0b e%0b d%0h l%0d p%0d o%0b u%0b exp v%0b e%0b d%0h l%0d p%0d o%0b u%0b",
                         i, data_valid, pkt_end, data_out, level, pkt_count, overflow, underflow,
                         m_dv, m_pend, m_dout, mq.size(), m_hdrs(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_overflow();
        test_back_to_back_full();
        test_underflow();
        test_soft_reset();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
